// File: rtl/pcm_serializer_pkg.sv
// Shared types and elaboration-time parameter check for the PCM serializer.
package pcm_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

  // A frame must hold the sync slot plus every sample bit, and the divider
  // needs at least one clk per bclk half-period.
  function automatic bit params_ok(input int unsigned n,
                                   input int unsigned bclk_div,
                                   input int unsigned frame_bits);
    return (frame_bits >= n + 1) && (bclk_div >= 1);
  endfunction

endpackage

// File: rtl/pcm_serializer_if.sv
// Sample handshake between the FIR output stage and the serializer.
interface pcm_serializer_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/pcm_serializer_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV while run is high and
// flags the clk edge on which bclk falls.
module bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall
);

  localparam int unsigned CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  assign wrap = run && (div_cnt_q == DIV_LAST);
  assign fall = wrap && bclk_q;
  assign bclk = bclk_q;

  // Divider count and bclk toggle; both parked at 0 outside RUN.
  always_comb begin
    div_cnt_d = '0;
    bclk_d    = 1'b0;
    if (run) begin
      div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
      bclk_d    = wrap ? ~bclk_q : bclk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/pcm_serializer.sv
// PCM serializer: buffers one sample and shifts it MSB-first in DSP-style
// frames (one-slot fsync, zero padding) on a generated bit clock.
module pcm_serializer
  import pcm_serializer_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FRAME_BITS = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  pcm_serializer_if.slave         s_if,
  output logic                    bclk,
  output logic                    fsync,
  output logic                    sdata,
  output logic                    busy,
  output logic                    underrun
);

  if (!params_ok(N, BCLK_DIV, FRAME_BITS)) begin : g_param_check
    $fatal(1, "pcm_serializer: need FRAME_BITS >= N+1 and BCLK_DIV >= 1");
  end

  localparam int unsigned SW = $clog2(FRAME_BITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_BITS - 1);
  localparam logic [SW-1:0] SLOT_N    = SW'(N);

  ser_state_t    state_q, state_d;
  logic [N-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          fsync_q, fsync_d;
  logic          sdata_q, sdata_d;
  logic          underrun_q, underrun_d;
  logic          fall;
  logic          accept;

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q == RUN),
    .bclk (bclk),
    .fall (fall)
  );

  assign s_if.in_ready = !hold_full_q;
  assign accept        = s_if.in_valid && !hold_full_q;
  assign fsync         = fsync_q;
  assign sdata         = sdata_q;
  assign busy          = (state_q == RUN);
  assign underrun      = underrun_q;

  // Next-state: hold-register accept, frame loads and per-slot shifting.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    slot_d      = slot_q;
    fsync_d     = fsync_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;

    // Accept only happens with the hold register empty, and loads only
    // with it full, so the clear below never races a capture.
    if (accept) begin
      hold_d      = s_if.in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        fsync_d = 1'b0;
        sdata_d = 1'b0;
        slot_d  = '0;
        if (ena && hold_full_q) begin
          state_d     = RUN;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          fsync_d     = 1'b1;
        end
      end
      RUN: begin
        if (fall) begin
          if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            sdata_d = 1'b0;
            if (!ena) begin
              state_d = IDLE;
              fsync_d = 1'b0;
              shift_d = '0;
            end else if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              fsync_d     = 1'b1;
            end else begin
              shift_d    = '0;
              fsync_d    = 1'b1;
              underrun_d = 1'b1;
            end
          end else begin
            slot_d  = slot_q + 1'b1;
            fsync_d = 1'b0;
            if (slot_q < SLOT_N) begin
              sdata_d = shift_q[N-1];
              shift_d = shift_q << 1;
            end else begin
              sdata_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      slot_q      <= '0;
      fsync_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      slot_q      <= slot_d;
      fsync_q     <= fsync_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcm_serializer.sv
// Bench for pcm_serializer: a frame-timing model predicts every output on
// every clk; directed frames are also captured and pinned to literals.
module tb_pcm_serializer;

  localparam int N          = 16;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_BITS = 31;
  localparam int FRAME_CLK  = FRAME_BITS * 2 * BCLK_DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic bclk, fsync, sdata, busy, underrun;

  pcm_serializer_if #(.N(N)) s_if ();

  pcm_serializer #(
    .N          (N),
    .BCLK_DIV   (BCLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .ena      (ena),
    .s_if     (s_if),
    .bclk     (bclk),
    .fsync    (fsync),
    .sdata    (sdata),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running frame is just a clk offset m_t into a 248-clk frame
  // carrying m_frame; everything visible is derived from m_t arithmetic.
  bit           m_run = 1'b0;
  bit           m_hold_full = 1'b0;
  bit           m_und = 1'b0;
  bit           m_acc;
  logic [N-1:0] m_hold = '0;
  logic [N-1:0] m_frame = '0;
  int           m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_hold_full = 1'b0; m_und = 1'b0;
      m_t = 0; m_hold = '0; m_frame = '0;
    end else begin
      m_acc = s_if.in_valid && !m_hold_full;
      if (!m_run) begin
        m_und = 1'b0;
        if (ena && m_hold_full) begin
          m_run = 1'b1; m_t = 0; m_frame = m_hold; m_hold_full = 1'b0;
        end
      end else if (m_t == FRAME_CLK - 1) begin
        m_t = 0; m_und = 1'b0;
        if (!ena) m_run = 1'b0;
        else if (m_hold_full) begin m_frame = m_hold; m_hold_full = 1'b0; end
        else begin m_frame = '0; m_und = 1'b1; end
      end else begin
        m_t++; m_und = 1'b0;
      end
      if (m_acc) begin m_hold = s_if.in_data; m_hold_full = 1'b1; end
    end
  end

  always @(negedge clk) begin
    int   slot;
    logic eb, ef, es, eu, ey;
    if (rst_n === 1'b1) begin
      slot = m_t / (2 * BCLK_DIV);
      eb = 1'b0; ef = 1'b0; es = 1'b0; eu = 1'b0; ey = m_run;
      if (m_run) begin
        eb = ((m_t / BCLK_DIV) % 2) == 1;
        ef = (slot == 0);
        es = (slot >= 1 && slot <= N) ? m_frame[N-slot] : 1'b0;
        eu = m_und;
      end
      check("m_in_ready", 32'(s_if.in_ready), 32'(!m_hold_full));
      check("m_bclk", 32'(bclk), 32'(eb));
      check("m_fsync", 32'(fsync), 32'(ef));
      check("m_sdata", 32'(sdata), 32'(es));
      check("m_busy", 32'(busy), 32'(ey));
      check("m_underrun", 32'(underrun), 32'(eu));
    end
  end

  // Called at a negedge; holds in_valid until the sample is taken.
  task automatic send(input logic [N-1:0] v);
    logic rdy;
    int   n;
    s_if.in_data  = v;
    s_if.in_valid = 1'b1;
    n = 0;
    forever begin
      rdy = s_if.in_ready;
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 4000) begin check("send_timeout", n, 0); break; end
    end
    s_if.in_valid = 1'b0;
  endtask

  task automatic wait_rise(output int waited);
    logic pf;
    pf = fsync;
    waited = 0;
    forever begin
      @(negedge clk);
      if (fsync && !pf) break;
      pf = fsync;
      waited++;
      if (waited > 4000) begin check("fsync_timeout", waited, 0); break; end
    end
  endtask

  // Receiver view of one frame: sdata sampled on each bclk rise.
  task automatic capture(input int drop_c, output logic [30:0] bits,
                         output int fs_cnt, output int und_cnt, output int waited);
    logic pb;
    bits = '0; fs_cnt = 0; und_cnt = 0; pb = 1'b0;
    wait_rise(waited);
    for (int c = 0; c < FRAME_CLK; c++) begin
      if (c > 0) @(negedge clk);
      if (bclk && !pb) bits = {bits[29:0], sdata};
      pb = bclk;
      fs_cnt += int'(fsync);
      und_cnt += int'(underrun);
      if (c == drop_c) ena = 1'b0;
    end
  endtask

  logic [30:0] ba, bb, bc;
  int fa, fb, fc, ua, ub, uc, wa, wb, wc;

  initial begin
    rst_n = 1'b1; ena = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_bclk", 32'(bclk), 0);
    check("rst_fsync", 32'(fsync), 0);
    check("rst_sdata", 32'(sdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_in_ready", 32'(s_if.in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_bclk", 32'(bclk), 0);

    // Single sample, then an underrun frame
    ena = 1'b1;
    send(16'h8001);
    capture(-1, ba, fa, ua, wa);
    check("s1_latency", wa, 0);
    check("s1_bits", 32'(ba), 32'h2000_4000);
    check("s1_fsync_len", fa, 8);
    check("s1_underrun", ua, 0);
    capture(-1, bb, fb, ub, wb);
    check("ur_contig", wb, 0);
    check("ur_bits", 32'(bb), 0);
    check("ur_pulse", ub, 1);

    // Back-to-back plus a held-off third sample
    send(16'd1000);
    fork
      begin send(16'hFC18); send(16'h1234); end
      begin
        capture(-1, ba, fa, ua, wa);
        capture(-1, bb, fb, ub, wb);
        capture(-1, bc, fc, uc, wc);
      end
    join
    check("b2b_a_bits", 32'(ba), 32'h00FA_0000);
    check("b2b_b_bits", 32'(bb), 32'h3F06_0000);
    check("b2b_b_contig", wb, 0);
    check("bp_c_bits", 32'(bc), 32'h048D_0000);
    check("bp_c_contig", wc, 0);
    check("b2b_underrun", ua + ub + uc, 0);

    // ena dropped in slot 5; queued sample survives IDLE
    send(16'hA5A5);
    fork
      send(16'h0F0F);
      capture(45, ba, fa, ua, wa);
    join
    check("drop_bits", 32'(ba), 32'h2969_4000);
    repeat (5) @(negedge clk);
    check("drop_busy", 32'(busy), 0);
    check("drop_bclk", 32'(bclk), 0);
    check("drop_hold_kept", 32'(s_if.in_ready), 0);
    ena = 1'b1;
    capture(-1, ba, fa, ua, wa);
    check("restart_latency", wa, 0);
    check("restart_bits", 32'(ba), 32'h03C3_C000);

    // Async reset at slot 5 with a sample waiting in hold
    send(16'hFFFF);
    wait_rise(wa);
    send(16'h7777);
    repeat (44) @(negedge clk);
    check("pre_rst_bclk", 32'(bclk), 1);
    check("pre_rst_sdata", 32'(sdata), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bclk", 32'(bclk), 0);
    check("mid_rst_fsync", 32'(fsync), 0);
    check("mid_rst_sdata", 32'(sdata), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(s_if.in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_discard", 32'(busy), 0);
    send(16'h00FF);
    capture(-1, ba, fa, ua, wa);
    check("post_rst_latency", wa, 0);
    check("post_rst_bits", 32'(ba), 32'h003F_C000);
    check("post_rst_fsync_len", fa, 8);

    ena = 1'b0;
    repeat (FRAME_CLK + 10) @(negedge clk);
    check("end_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
